// File: rtl/spi_pkg.sv
// Shared types and frame geometry for the register-access SPI master.
// The 17-bit frame carries rw, addr and wdata; an 18th sclk edge lets the slave commit.
package spi_pkg;

    localparam int unsigned FRAME_BITS    = 17;
    localparam int unsigned SCLK_EDGES    = 18;
    localparam int unsigned RD_FIRST_EDGE = 10;
    localparam int unsigned RD_LAST_EDGE  = 17;
    localparam int unsigned EDGE_W        = $clog2(SCLK_EDGES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } spi_state_e;

    // Read frames send zeros in the data slot so the slave sees a clean turnaround.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic       rw,
                                                           input logic [7:0] addr,
                                                           input logic [7:0] wdata);
        return {rw, addr, (rw ? wdata : 8'h00)};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Serial clock generator: divides clk by CLK_DIV per half-period while enabled.
// Emits a tick every CLK_DIV cycles and rise/fall strobes for the edge sclk is about to take.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic toggle,
    output logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             sclk_q;

    assign tick = en && (cnt_q == CNT_MAX);
    assign rise = tick && toggle && !sclk_q;
    assign fall = tick && toggle && sclk_q;
    assign sclk = sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            if (tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (tick && toggle) begin
                sclk_q <= ~sclk_q;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master issuing 17-bit register read/write frames (rw, addr, wdata) with 18 sclk edges.
// Mode-0 style: mosi updates on sclk fall, read data captured on the falls after edges 10..17.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic       ss
);

    spi_state_e            state_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [7:0]            rd_sr_q;
    logic [EDGE_W-1:0]     edge_cnt_q;
    logic                  rw_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ss_q;
    logic                  mosi_q;
    logic [7:0]            rdata_q;

    logic gen_en;
    logic gen_toggle;
    logic tick;
    logic rise;
    logic fall;
    logic shift_end;
    logic in_rd_window;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (gen_en),
        .toggle(gen_toggle),
        .sclk  (sclk),
        .tick  (tick),
        .rise  (rise),
        .fall  (fall)
    );

    // After the last fall, one more low half-period elapses before ss is released.
    assign shift_end    = !sclk && (edge_cnt_q == EDGE_W'(SCLK_EDGES));
    assign in_rd_window = (edge_cnt_q >= EDGE_W'(RD_FIRST_EDGE)) &&
                          (edge_cnt_q <= EDGE_W'(RD_LAST_EDGE));

    always_comb begin
        gen_en     = 1'b0;
        gen_toggle = 1'b0;
        unique case (state_q)
            StSetup: begin
                gen_en     = 1'b1;
                gen_toggle = 1'b1;
            end
            StShift: begin
                gen_en     = 1'b1;
                gen_toggle = !shift_end;
            end
            StHold: begin
                gen_en     = 1'b1;
            end
            default: begin
                gen_en     = 1'b0;
                gen_toggle = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            rd_sr_q    <= '0;
            edge_cnt_q <= '0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            rdata_q    <= 8'h00;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // DONE shares the accept path so a held start relaunches without a gap.
                StIdle, StDone: begin
                    busy_q <= 1'b0;
                    ss_q   <= 1'b1;
                    mosi_q <= 1'b0;
                    if (start) begin
                        frame_q    <= build_frame(rw, addr, wdata);
                        rw_q       <= rw;
                        mosi_q     <= rw;
                        ss_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        edge_cnt_q <= '0;
                        rd_sr_q    <= '0;
                        state_q    <= StSetup;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StSetup: begin
                    if (rise) begin
                        edge_cnt_q <= edge_cnt_q + 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    if (rise) begin
                        edge_cnt_q <= edge_cnt_q + 1'b1;
                    end
                    if (fall) begin
                        frame_q <= frame_q << 1;
                        mosi_q  <= frame_q[FRAME_BITS-2];
                        if (in_rd_window) begin
                            rd_sr_q <= {rd_sr_q[6:0], miso};
                        end
                    end
                    if (tick && shift_end) begin
                        ss_q    <= 1'b1;
                        mosi_q  <= 1'b0;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (tick) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                        if (!rw_q) begin
                            rdata_q <= rd_sr_q;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign mosi  = mosi_q;
    assign ss    = ss_q;

    a_mosi_stable: assert property (@(posedge clk) disable iff (!rst_n) sclk |-> $stable(mosi));
    a_done_pulse:  assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
    a_done_idle:   assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master at CLK_DIV=2 and CLK_DIV=1, each with a register-file slave.
// Slave shifts mosi on sclk rise, drives read data from rise 10, commits writes on rise 18.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_v;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    wire  [1:0] busy_v;
    wire  [1:0] done_v;
    wire  [1:0] sclk_v;
    wire  [1:0] mosi_v;
    wire  [1:0] miso_v;
    wire  [1:0] ss_v;
    wire  [7:0] rdata0;
    wire  [7:0] rdata1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_v[0]), .done(done_v[0]), .rdata(rdata0), .sclk(sclk_v[0]),
        .mosi(mosi_v[0]), .miso(miso_v[0]), .ss(ss_v[0])
    );

    spi_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_v[1]), .done(done_v[1]), .rdata(rdata1), .sclk(sclk_v[1]),
        .mosi(mosi_v[1]), .miso(miso_v[1]), .ss(ss_v[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_slave
        logic [7:0]   mem [256];
        logic [255:0] valid      = '0;
        logic [16:0]  rx         = '0;
        logic [16:0]  last_rx    = '0;
        logic [7:0]   tx         = '0;
        int           rises      = 0;
        int           last_rises = 0;
        logic         miso_q     = 1'b0;
        logic [7:0]   rd_byte;

        // Unwritten address 0xE9 reads back the preloaded value 0xB9.
        always_comb begin
            rd_byte = 8'h00;
            if (valid[rx[7:0]]) rd_byte = mem[rx[7:0]];
            else if (rx[7:0] == 8'hE9) rd_byte = 8'hB9;
        end

        always @(posedge sclk_v[g] or posedge ss_v[g]) begin
            if (ss_v[g]) begin
                last_rises <= rises;
                if (rises != 0) last_rx <= rx;
                rises  <= 0;
                miso_q <= 1'b0;
            end else begin
                rises <= rises + 1;
                if (rises < 17) rx <= {rx[15:0], mosi_v[g]};
                if (rises == 9) begin
                    miso_q <= rd_byte[7];
                    tx     <= rd_byte << 1;
                end else if (rises > 9 && rises < 17) begin
                    miso_q <= tx[7];
                    tx     <= tx << 1;
                end else begin
                    miso_q <= 1'b0;
                end
                if (rises == 17 && rx[16]) begin
                    mem[rx[15:8]]   <= rx[7:0];
                    valid[rx[15:8]] <= 1'b1;
                end
            end
        end

        assign miso_v[g] = miso_q;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves the caller 1 time unit into cycle 1 of the accepted frame.
    task automatic send(input int w, input logic r, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        rw         = r;
        addr       = a;
        wdata      = d;
        start_v[w] = 1'b1;
        @(posedge clk);
        #1;
        start_v[w] = 1'b0;
    endtask

    task automatic wait_done(input int w, output int cyc, output logic [7:0] trace);
        cyc      = 1;
        trace    = '0;
        trace[0] = sclk_v[w];
        while (done_v[w] !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc <= 8) trace[cyc-1] = sclk_v[w];
        end
        check("done_seen", 32'(done_v[w]), 32'd1);
    endtask

    int         cyc;
    int         n_done;
    logic [7:0] tr;

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        rw      = 1'b0;
        addr    = 8'h00;
        wdata   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss",    32'(ss_v[0]),   32'd1);
        check("rst_sclk",  32'(sclk_v[0]), 32'd0);
        check("rst_mosi",  32'(mosi_v[0]), 32'd0);
        check("rst_busy",  32'(busy_v[0]), 32'd0);
        check("rst_done",  32'(done_v[0]), 32'd0);
        check("rst_rdata", 32'(rdata0),    32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Write 0x5A to 0x21
        send(0, 1'b1, 8'h21, 8'h5A);
        check("w_busy", 32'(busy_v[0]), 32'd1);
        check("w_ss",   32'(ss_v[0]),   32'd0);
        check("w_mosi", 32'(mosi_v[0]), 32'd1);
        wait_done(0, cyc, tr);
        check("w_lat",       32'(cyc),                  32'd77);
        check("w_sclk",      32'(tr),                   32'hCC);
        check("w_busy_done", 32'(busy_v[0]),            32'd0);
        check("w_frame",     32'(g_slave[0].last_rx),   32'h1215A);
        check("w_edges",     32'(g_slave[0].last_rises), 32'd18);
        check("w_mem",       32'(g_slave[0].mem[8'h21]), 32'h5A);
        check("w_rdata",     32'(rdata0),               32'h00);
        @(posedge clk);
        #1;
        check("w_done_pulse", 32'(done_v[0]), 32'd0);
        check("w_idle_ss",    32'(ss_v[0]),   32'd1);

        // Read 0xE9 (preloaded 0xB9); wdata must not reach mosi
        send(0, 1'b0, 8'hE9, 8'hFF);
        wait_done(0, cyc, tr);
        check("r_lat",   32'(cyc),                32'd77);
        check("r_rdata", 32'(rdata0),             32'hB9);
        check("r_frame", 32'(g_slave[0].last_rx), 32'h0E900);

        // Write 0x3C to 0x10, then read it back with start held high
        @(negedge clk);
        rw = 1'b1; addr = 8'h10; wdata = 8'h3C; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rw = 1'b0;
        wait_done(0, cyc, tr);
        check("b2b_lat1",  32'(cyc),                   32'd77);
        check("b2b_frame", 32'(g_slave[0].last_rx),    32'h1103C);
        check("b2b_mem",   32'(g_slave[0].mem[8'h10]), 32'h3C);
        check("b2b_busy",  32'(busy_v[0]),             32'd0);
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check("b2b_relaunch_busy", 32'(busy_v[0]), 32'd1);
        check("b2b_relaunch_ss",   32'(ss_v[0]),   32'd0);
        wait_done(0, cyc, tr);
        check("b2b_lat2",   32'(cyc),                32'd77);
        check("b2b_rdata",  32'(rdata0),             32'h3C);
        check("b2b_frame2", 32'(g_slave[0].last_rx), 32'h01000);

        // Start pulse mid-frame with a different address is ignored
        send(0, 1'b1, 8'h44, 8'h77);
        cyc    = 1;
        n_done = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 20) begin
                start_v[0] = 1'b1; rw = 1'b1; addr = 8'h55; wdata = 8'h99;
            end
            if (cyc == 21) start_v[0] = 1'b0;
            if (done_v[0] === 1'b1) n_done++;
        end
        check("ign_dones", 32'(n_done),                  32'd1);
        check("ign_frame", 32'(g_slave[0].last_rx),      32'h14477);
        check("ign_addr",  32'(g_slave[0].valid[8'h55]), 32'd0);
        check("ign_mem",   32'(g_slave[0].mem[8'h44]),   32'h77);
        check("ign_rdata", 32'(rdata0),                  32'h3C);

        // Reset at rising edge 9 aborts the frame
        send(0, 1'b1, 8'h66, 8'hAA);
        cyc = 1;
        while (g_slave[0].rises != 9 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("abort_edge9", 32'(g_slave[0].rises), 32'd9);
        rst_n = 1'b0;
        #1;
        check("abort_ss",   32'(ss_v[0]),   32'd1);
        check("abort_sclk", 32'(sclk_v[0]), 32'd0);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done_v[0] === 1'b1) n_done++;
        end
        check("abort_no_done", 32'(n_done),                  32'd0);
        check("abort_no_wr",   32'(g_slave[0].valid[8'h66]), 32'd0);
        check("abort_rdata",   32'(rdata0),                  32'h00);
        send(0, 1'b0, 8'hE9, 8'h00);
        wait_done(0, cyc, tr);
        check("post_rst_lat",   32'(cyc),    32'd77);
        check("post_rst_rdata", 32'(rdata0), 32'hB9);

        // CLK_DIV=1 read
        send(1, 1'b0, 8'hE9, 8'h00);
        wait_done(1, cyc, tr);
        check("d1_lat",   32'(cyc),                32'd39);
        check("d1_sclk",  32'(tr),                 32'hAA);
        check("d1_rdata", 32'(rdata1),             32'hB9);
        check("d1_frame", 32'(g_slave[1].last_rx), 32'h0E900);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning sclk half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a frame; accepted only in IDLE.
REQ-005 SHALL have port rw  input  1  1 = write, 0 = read; sampled with start.
REQ-006 SHALL have port addr  input  8  register address; sampled with start.
REQ-007 SHALL have port wdata  input  8  write data; sampled with start, ignored for reads.
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-010 SHALL have port rdata  output  8  data returned by the last read frame.
REQ-011 SHALL have port sclk  output  1  serial clock to slave; idle low.
REQ-012 SHALL have port mosi  output  1  serial data to slave; MSB first.
REQ-013 SHALL have port miso  input  1  serial data from slave.
REQ-014 SHALL have port ss  output  1  slave select, active-low; idle high.

Function
REQ-015 Frame SHALL be 17 bits, shifted in this order: rw, addr[7:0], wdata[7:0]; for reads, wdata bits SHALL be driven as 0.
REQ-016 Every frame SHALL contain exactly 18 sclk rising edges; the 18th edge carries no data and lets the slave commit the write and release miso.
REQ-017 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-018 IDLE: ss=1, sclk=0, mosi=0; on start, latch the 17-bit frame, drive ss=0 and mosi=rw, then go to SETUP.
REQ-019 SETUP: hold for CLK_DIV cycles, then drive sclk rising (edge 1) and go to SHIFT.
REQ-020 SHIFT: sclk SHALL toggle every CLK_DIV cycles.
REQ-021 In SHIFT, on the falling edge after rising edge n (n = 1..16), mosi SHALL present frame bit n.
REQ-022 mosi SHALL change only while sclk is low and SHALL be stable across each rising edge.
REQ-023 For reads, miso SHALL be sampled on the falling edge after rising edges 10..17 and shifted into a read shift register MSB first.
REQ-024 After the falling edge that follows rising edge 18, the FSM SHALL go to HOLD with ss=1, sclk=0, mosi=0 for CLK_DIV cycles, then go to DONE.
REQ-025 DONE: for read frames, load rdata from the read shift register in this cycle; pulse done=1 for exactly one cycle, then return to IDLE.
REQ-026 rdata SHALL be unchanged by write frames.
REQ-027 Latency: done SHALL be high in cycle 38*CLK_DIV+1 after the start-accept edge (77 for CLK_DIV=2).
REQ-028 busy SHALL be low in DONE-to-IDLE return, so a start held high SHALL launch a new frame the cycle after done.
REQ-029 start while busy=1 SHALL be ignored, with no queuing.
REQ-030 Changes to rw, addr or wdata during a frame SHALL have no effect on that frame.
REQ-031 With CLK_DIV=1, sclk SHALL run at clk/2 with otherwise identical behaviour.

Reset
REQ-032 rst_n low SHALL immediately force: state=IDLE, ss=1, sclk=0, mosi=0, busy=0, done=0, rdata=8'h00, all counters and shift registers = 0.
REQ-033 Reset mid-frame SHALL abort the frame without a done pulse; ss high terminates the slave transaction.
REQ-034 Operation SHALL resume on the first clk edge after rst_n is released.

Structure
REQ-035 A shared package spi_pkg SHALL hold the FSM state enum, FRAME_BITS=17, SCLK_EDGES=18 and the read-capture window constants (10, 17).
REQ-036 A sub-module spi_clk_gen SHALL hold the CLK_DIV counter and produce sclk plus one-cycle rise/fall strobes; spi_master SHALL hold the FSM, the edge counter and the shift registers.

Verification
REQ-037 Write rw=1, addr=8'h21, wdata=8'h5A, CLK_DIV=2 -> mosi at rising edges 1..17 = 1,00100001,01011010; slave model reg[0x21]=8'h5A; done at cycle 77.
REQ-038 Read rw=0, addr=8'hE9, slave model preloaded reg[0xE9]=8'hB9 -> rdata=8'hB9 on the done cycle; mosi data bits all 0.
REQ-039 Write 8'h3C to 8'h10, then read 8'h10 with start held high -> second frame starts the cycle after the first done; rdata=8'h3C.
REQ-040 start pulsed at cycle 20 of a frame with different addr -> ignored; exactly one done; frame fields unchanged.
REQ-041 rst_n low at rising edge 9 of a frame -> ss=1, sclk=0 within the same cycle; no done pulse; next frame completes correctly.
REQ-042 CLK_DIV=1, read addr 8'hE9 -> sclk period 2 clk cycles, rdata=8'hB9, done at cycle 39.
